// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : CPU15 instruction-cycle controller. Generates the one-hot
//                fetch/decode/execute/write-back strobes and owns the program
//                counter. It applies jump and halt results from execute,
//                supports free-run and single-step, and counts retired
//                instructions with a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int unsigned          PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 STEP_MODE,
    input  logic                 JMP_EN,
    input  logic [PC_WIDTH-1:0]  JMP_ADDR,
    input  logic                 HLT_DET,
    output logic                 CLK_FT,
    output logic                 CLK_DC,
    output logic                 CLK_EX,
    output logic                 CLK_WB,
    output logic [PC_WIDTH-1:0]  P_COUNT,
    output logic                 HALTED,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] INSTR_CNT
);

    // Bit positions inside the one-hot state vector. The strobes and HALTED
    // are taken straight from these bits so they come out of flops.
    localparam int unsigned B_IDLE = 0;
    localparam int unsigned B_FT   = 1;
    localparam int unsigned B_DC   = 2;
    localparam int unsigned B_EX   = 3;
    localparam int unsigned B_WB   = 4;
    localparam int unsigned B_HALT = 5;

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_FT   = 6'b000010,
        S_DC   = 6'b000100,
        S_EX   = 6'b001000,
        S_WB   = 6'b010000,
        S_HALT = 6'b100000
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q,    pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic                  jmp_q,   jmp_d;
    logic [PC_WIDTH-1:0]   addr_q,  addr_d;
    logic                  hlt_q,   hlt_d;
    logic                  busy_q,  busy_d;

    // Next-state, program-counter and counter update rules.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        jmp_d   = jmp_q;
        addr_d  = addr_q;
        hlt_d   = hlt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FT;
                end
            end
            S_FT: state_d = S_DC;
            S_DC: state_d = S_EX;
            S_EX: begin
                // Execute-stage results are captured only here and consumed
                // on the following write-back exit.
                jmp_d   = JMP_EN;
                addr_d  = JMP_ADDR;
                hlt_d   = HLT_DET;
                state_d = S_WB;
            end
            S_WB: begin
                cnt_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                jmp_d = 1'b0;
                hlt_d = 1'b0;
                if (hlt_q) begin
                    // PC keeps pointing at the HLT instruction; halt beats jump.
                    state_d = S_HALT;
                end else begin
                    pc_d    = jmp_q ? addr_q : pc_q + PC_WIDTH'(1);
                    state_d = STEP_MODE ? S_IDLE : S_FT;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;  // recover from a corrupted one-hot vector
        endcase
        busy_d = (state_d == S_FT) || (state_d == S_DC) ||
                 (state_d == S_EX) || (state_d == S_WB);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            jmp_q   <= 1'b0;
            addr_q  <= '0;
            hlt_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            jmp_q   <= jmp_d;
            addr_q  <= addr_d;
            hlt_q   <= hlt_d;
            busy_q  <= busy_d;
        end
    end

    assign CLK_FT    = state_q[B_FT];
    assign CLK_DC    = state_q[B_DC];
    assign CLK_EX    = state_q[B_EX];
    assign CLK_WB    = state_q[B_WB];
    assign HALTED    = state_q[B_HALT];
    assign BUSY      = busy_q;
    assign P_COUNT   = pc_q;
    assign INSTR_CNT = cnt_q;

    // The IDLE bit carries no output of its own.
    logic w_idle_unused;
    assign w_idle_unused = state_q[B_IDLE];

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Self-checking bench for phase_sequencer with a cycle-level
//                behavioural model of the instruction cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        STEP_MODE = 1'b0;
    logic        JMP_EN = 1'b0;
    logic [7:0]  JMP_ADDR = 8'h00;
    logic        HLT_DET = 1'b0;

    logic        CLK_FT, CLK_DC, CLK_EX, CLK_WB, HALTED, BUSY;
    logic [7:0]  P_COUNT;
    logic [15:0] INSTR_CNT;

    logic        s_ft, s_dc, s_ex, s_wb, s_halted, s_busy;
    logic [7:0]  s_pc;
    logic [2:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase -1 idle, 0..3 = FT/DC/EX/WB, 4 = halted
    int m_phase = -1;
    int m_pc = 0, m_cnt = 0, m_cnt_small = 0;
    int m_jmp = 0, m_addr = 0, m_hlt = 0;

    always #5 CLK = ~CLK;

    phase_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STEP_MODE(STEP_MODE),
        .JMP_EN(JMP_EN), .JMP_ADDR(JMP_ADDR), .HLT_DET(HLT_DET),
        .CLK_FT(CLK_FT), .CLK_DC(CLK_DC), .CLK_EX(CLK_EX), .CLK_WB(CLK_WB),
        .P_COUNT(P_COUNT), .HALTED(HALTED), .BUSY(BUSY), .INSTR_CNT(INSTR_CNT)
    );

    // Small-counter instance used to reach saturation quickly
    phase_sequencer #(.CNT_WIDTH(3)) sat_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STEP_MODE(STEP_MODE),
        .JMP_EN(JMP_EN), .JMP_ADDR(JMP_ADDR), .HLT_DET(HLT_DET),
        .CLK_FT(s_ft), .CLK_DC(s_dc), .CLK_EX(s_ex), .CLK_WB(s_wb),
        .P_COUNT(s_pc), .HALTED(s_halted), .BUSY(s_busy), .INSTR_CNT(s_cnt)
    );

    task automatic model_step();
        if (RESET) begin
            m_phase = -1; m_pc = 0; m_cnt = 0; m_cnt_small = 0;
            m_jmp = 0; m_hlt = 0; m_addr = 0;
        end else begin
            case (m_phase)
                -1: if (START) m_phase = 0;
                0, 1: m_phase = m_phase + 1;
                2: begin
                    m_jmp = int'(JMP_EN); m_hlt = int'(HLT_DET); m_addr = int'(JMP_ADDR);
                    m_phase = 3;
                end
                3: begin
                    m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
                    m_cnt_small = (m_cnt_small + 1 > 7) ? 7 : m_cnt_small + 1;
                    if (m_hlt != 0) m_phase = 4;
                    else begin
                        m_pc = (m_jmp != 0) ? m_addr : (m_pc + 1) % 256;
                        m_phase = STEP_MODE ? -1 : 0;
                    end
                end
                default: m_phase = 4;
            endcase
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; START = 1'b0; JMP_EN = 1'b0; HLT_DET = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    // Free-run until the DUT shows EX at the given PC; expiry is a failure.
    task automatic wait_ex_at(input logic [7:0] pc);
        int k;
        for (k = 0; k < 1200; k++) begin
            if (CLK_EX === 1'b1 && P_COUNT === pc) break;
            tick();
        end
        n_checks++;
        if (k == 1200) begin
            n_fail++;
            $display("FAIL wait_ex_at: EX at pc %0h never seen (pc now %0h)", pc, P_COUNT);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++;
        if ({CLK_FT, CLK_DC, CLK_EX, CLK_WB, HALTED, BUSY} !== 6'b0 ||
            P_COUNT !== 8'h00 || INSTR_CNT !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: strobes/halt/busy=%b pc=%h cnt=%h, required 0/00/0000",
                     {CLK_FT, CLK_DC, CLK_EX, CLK_WB, HALTED, BUSY}, P_COUNT, INSTR_CNT);
        end
    endtask

    task automatic test_free_run();
        logic [3:0] exp_s;
        do_reset();
        STEP_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_s = 4'b0001 << (k % 4);
            n_checks++;
            if ({CLK_WB, CLK_EX, CLK_DC, CLK_FT} !== exp_s || P_COUNT !== 8'(k / 4) || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL free_run k=%0d: wb/ex/dc/ft=%b pc=%h busy=%b, required %b pc=%h busy=1",
                         k, {CLK_WB, CLK_EX, CLK_DC, CLK_FT}, P_COUNT, BUSY, exp_s, 8'(k / 4));
            end
            tick();
        end
        n_checks++;
        if (P_COUNT !== 8'h03 || INSTR_CNT !== 16'd3 || CLK_FT !== 1'b1) begin
            n_fail++;
            $display("FAIL free_run_end: pc=%h cnt=%0d ft=%b, required pc=03 cnt=3 ft=1",
                     P_COUNT, INSTR_CNT, CLK_FT);
        end
    endtask

    task automatic test_jump();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            STEP_MODE = 1'b0; START = 1'b1;
            tick();
            START = 1'b0;
            wait_ex_at(8'h05);
            JMP_EN = (pass == 1); JMP_ADDR = 8'h0A;
            tick();
            JMP_EN = 1'b0; JMP_ADDR = 8'($urandom);
            n_checks++;
            if (P_COUNT !== 8'h05 || CLK_WB !== 1'b1) begin
                n_fail++;
                $display("FAIL jump_wb pass %0d: pc=%h wb=%b, required pc=05 wb=1", pass, P_COUNT, CLK_WB);
            end
            tick();
            n_checks++;
            if (P_COUNT !== ((pass == 1) ? 8'h0A : 8'h06) || CLK_FT !== 1'b1) begin
                n_fail++;
                $display("FAIL jump_ft pass %0d: pc=%h ft=%b, required pc=%h ft=1",
                         pass, P_COUNT, CLK_FT, (pass == 1) ? 8'h0A : 8'h06);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        STEP_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        wait_ex_at(8'h0E);
        HLT_DET = 1'b1; JMP_EN = 1'b1; JMP_ADDR = 8'($urandom);
        tick();
        HLT_DET = 1'b0; JMP_EN = 1'b0;
        tick();
        n_checks++;
        if (HALTED !== 1'b1 || BUSY !== 1'b0 || P_COUNT !== 8'h0E || INSTR_CNT !== 16'd15) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b busy=%b pc=%h cnt=%0d, required 1/0/0e/15",
                     HALTED, BUSY, P_COUNT, INSTR_CNT);
        end
        START = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if ({CLK_FT, CLK_DC, CLK_EX, CLK_WB} !== 4'b0 || HALTED !== 1'b1 || P_COUNT !== 8'h0E) begin
                n_fail++;
                $display("FAIL halt_hold k=%0d: strobes=%b halted=%b pc=%h, required 0000/1/0e",
                         k, {CLK_FT, CLK_DC, CLK_EX, CLK_WB}, HALTED, P_COUNT);
            end
        end
        START = 1'b0;
        do_reset();
        n_checks++;
        if (HALTED !== 1'b0 || BUSY !== 1'b0 || P_COUNT !== 8'h00) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%b busy=%b pc=%h, required 0/0/00", HALTED, BUSY, P_COUNT);
        end
    endtask

    task automatic test_step_mode();
        int ft_seen = 0;
        do_reset();
        STEP_MODE = 1'b1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL step_idle p=%0d: busy=%b, required 0", p, BUSY);
            end
            START = 1'b1;
            tick();
            START = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if (CLK_FT === 1'b1) ft_seen++;
                tick();
            end
        end
        n_checks++;
        if (ft_seen != 3 || P_COUNT !== 8'h03 || INSTR_CNT !== 16'd3 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL step_end: fetches=%0d pc=%h cnt=%0d busy=%b, required 3/03/3/0",
                     ft_seen, P_COUNT, INSTR_CNT, BUSY);
        end
        STEP_MODE = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        STEP_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        wait_ex_at(8'h00);
        JMP_EN = 1'b1; JMP_ADDR = 8'hFF;
        tick();
        JMP_EN = 1'b0;
        tick();
        n_checks++;
        if (P_COUNT !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_jump: pc=%h, required ff", P_COUNT);
        end
        wait_ex_at(8'hFF);
        tick();
        tick();
        n_checks++;
        if (P_COUNT !== 8'h00 || CLK_FT !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: pc=%h ft=%b, required 00/1", P_COUNT, CLK_FT);
        end
        for (int k = 0; k < 32; k++) tick();
        n_checks++;
        if (INSTR_CNT !== 16'd10 || s_cnt !== 3'd7 || s_pc !== P_COUNT) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d small_cnt=%0d small_pc=%h, required 10/7/%h",
                     INSTR_CNT, s_cnt, s_pc, P_COUNT);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        STEP_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RESET = 1'b1;               // asserted during DC
        tick();
        RESET = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0 || CLK_EX !== 1'b0 || P_COUNT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dc: busy=%b ex=%b pc=%h, required 0/0/00", BUSY, CLK_EX, P_COUNT);
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();             // now in EX
        JMP_EN = 1'b1; HLT_DET = 1'b1; JMP_ADDR = 8'h33; RESET = 1'b1;
        tick();
        JMP_EN = 1'b0; HLT_DET = 1'b0; RESET = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_ex_at(8'h01);
        JMP_EN = 1'b1; HLT_DET = 1'b1; JMP_ADDR = 8'h77;
        tick();                     // latched, now in WB
        JMP_EN = 1'b0; HLT_DET = 1'b0; RESET = 1'b1;
        tick();
        RESET = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (P_COUNT !== 8'h01 || HALTED !== 1'b0 || CLK_FT !== 1'b1 || INSTR_CNT !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_stale: pc=%h halted=%b ft=%b cnt=%0d, required 01/0/1/1",
                     P_COUNT, HALTED, CLK_FT, INSTR_CNT);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            RESET     = ($urandom_range(0, 39) == 0);
            START     = ($urandom_range(0, 2) == 0);
            STEP_MODE = $urandom_range(0, 1) == 1;
            JMP_EN    = ($urandom_range(0, 3) == 0);
            HLT_DET   = ($urandom_range(0, 11) == 0);
            JMP_ADDR  = 8'($urandom);
            tick();
            n_checks++;
            if (CLK_FT !== (m_phase == 0) || CLK_DC !== (m_phase == 1) ||
                CLK_EX !== (m_phase == 2) || CLK_WB !== (m_phase == 3) ||
                HALTED !== (m_phase == 4) || BUSY !== (m_phase >= 0 && m_phase <= 3) ||
                P_COUNT !== 8'(m_pc) || INSTR_CNT !== 16'(m_cnt) || s_cnt !== 3'(m_cnt_small)) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random c=%0d: ft/dc/ex/wb=%b%b%b%b halted=%b busy=%b pc=%h cnt=%0d small=%0d, required phase=%0d pc=%h cnt=%0d small=%0d",
                             c, CLK_FT, CLK_DC, CLK_EX, CLK_WB, HALTED, BUSY, P_COUNT, INSTR_CNT, s_cnt,
                             m_phase, 8'(m_pc), m_cnt, m_cnt_small);
                errs++;
            end
        end
        RESET = 1'b0; START = 1'b0; JMP_EN = 1'b0; HLT_DET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_jump();
        test_halt();
        test_step_mode();
        test_wrap_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
